// File: rtl/alu64.sv
// Registered 64-bit ALU: pass-B, add, subtract, AND, OR and optional XOR, with N/Z/V/C flags and 1-cycle latency.
// Define ALU64_XOR_EN to enable XOR on cntrl 110; when it is undefined, 110 behaves as a reserved code.
module alu64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             out_valid
);

  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_RSVD_1 = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_XOR    = 3'b110,
    OP_RSVD_7 = 3'b111
  } op_e;

  op_e              op;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             c_msb;
  logic             c_top;

  logic [WIDTH-1:0] result_d,   result_q;
  logic             carry_d,    carry_q;
  logic             overflow_d, overflow_q;
  logic             negative_q, zero_q, out_valid_q;

  // Subtract is A + ~B + 1, so one adder serves both ADD and SUB.
  assign op     = op_e'(cntrl);
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~B : B;
  assign sum    = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign c_top  = sum[WIDTH];
  assign c_msb  = A[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (op)
      OP_PASS_B: result_d = B;
      OP_ADD, OP_SUB: begin
        result_d   = sum[WIDTH-1:0];
        carry_d    = c_top;
        overflow_d = c_msb ^ c_top;
      end
      OP_AND:    result_d = A & B;
      OP_OR:     result_d = A | B;
`ifdef ALU64_XOR_EN
      OP_XOR:    result_d = A ^ B;
`else
      OP_XOR:    result_d = '0;
`endif
      OP_RSVD_1, OP_RSVD_7: result_d = '0;
      default:   result_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; in_valid acts as the load enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q   <= result_d;
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
        negative_q <= result_d[WIDTH-1];
        zero_q     <= (result_d == '0);
      end
    end
  end

  assign result    = result_q;
  assign negative  = negative_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign carry_out = carry_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu64.sv
// Self-checking bench for alu64: a behavioural model is compared against the DUT every cycle,
// with literal expectations for the directed corner vectors.
module tb_alu64;

  typedef struct packed {
    logic [63:0] r;
    logic        co;
    logic        ov;
    logic        neg;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] A, B;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        negative, zero, overflow, carry_out, out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t exp_s;
  logic exp_valid;
  logic cmp_en = 1'b0;

  localparam logic [2:0] C_PASS = 3'b000, C_R1 = 3'b001, C_ADD = 3'b010, C_SUB = 3'b011,
                         C_AND = 3'b100, C_OR = 3'b101, C_XOR = 3'b110, C_R7 = 3'b111;

  alu64 #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .A(A), .B(B), .cntrl(cntrl),
    .result(result), .negative(negative), .zero(zero), .overflow(overflow),
    .carry_out(carry_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference rules: unsigned wrap detects carry, operand/result signs detect overflow.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] c);
    exp_t e;
    e = '0;
    case (c)
      C_PASS: e.r = b;
      C_ADD: begin
        e.r  = a + b;
        e.co = (e.r < a);
        e.ov = (a[63] == b[63]) && (e.r[63] != a[63]);
      end
      C_SUB: begin
        e.r  = a - b;
        e.co = (a >= b);
        e.ov = (a[63] != b[63]) && (e.r[63] != a[63]);
      end
      C_AND: e.r = a & b;
      C_OR:  e.r = a | b;
`ifdef ALU64_XOR_EN
      C_XOR: e.r = a ^ b;
`endif
      default: e.r = '0;
    endcase
    e.neg = e.r[63];
    e.z   = (e.r == 64'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_lit(input string name, input logic [63:0] r, input logic co,
                           input logic ov, input logic neg, input logic z, input logic v);
    check({name, ".result"},    result,    r);
    check({name, ".carry_out"}, {63'd0, carry_out}, {63'd0, co});
    check({name, ".overflow"},  {63'd0, overflow},  {63'd0, ov});
    check({name, ".negative"},  {63'd0, negative},  {63'd0, neg});
    check({name, ".zero"},      {63'd0, zero},      {63'd0, z});
    check({name, ".out_valid"}, {63'd0, out_valid}, {63'd0, v});
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the model updated for that edge.
  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic [2:0] c, input logic v);
    A = a; B = b; cntrl = c; in_valid = v;
    @(posedge clk);
    if (v) exp_s = model(a, b, c);
    exp_valid = v;
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc.result",    result, exp_s.r);
      check("cyc.carry_out", {63'd0, carry_out}, {63'd0, exp_s.co});
      check("cyc.overflow",  {63'd0, overflow},  {63'd0, exp_s.ov});
      check("cyc.negative",  {63'd0, negative},  {63'd0, exp_s.neg});
      check("cyc.zero",      {63'd0, zero},      {63'd0, exp_s.z});
      check("cyc.out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
    end
  end

  initial begin
    logic [2:0] rand_ops [5];
    rand_ops = '{C_PASS, C_SUB, C_AND, C_OR, C_XOR};

    // An operation held on the inputs during reset must be discarded.
    reset = 1'b1; in_valid = 1'b1; A = 64'd1; B = 64'd1; cntrl = C_ADD;
    exp_s = '0; exp_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_lit("in_reset", 64'd0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_lit("post_reset", 64'd0, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;

    apply(64'd1, 64'd1, C_ADD, 1'b1);
    check_lit("add_1_1", 64'd2, 0, 0, 0, 0, 1);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, C_ADD, 1'b1);
    check_lit("add_wrap", 64'd0, 1, 0, 0, 1, 1);
    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, C_ADD, 1'b1);
    check_lit("add_min_min", 64'd0, 1, 1, 0, 1, 1);
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, C_ADD, 1'b1);
    check_lit("add_max_1", 64'h8000_0000_0000_0000, 0, 1, 1, 0, 1);
    apply(64'h111, 64'h111, C_SUB, 1'b1);
    check_lit("sub_eq", 64'd0, 1, 0, 0, 1, 1);
    apply(64'h8000_0000_0000_0000, 64'h0FFF_FFFF_FFFF_FFFF, C_SUB, 1'b1);
    check_lit("sub_ovf", 64'h7000_0000_0000_0001, 1, 1, 0, 0, 1);
    apply(64'd1, 64'd2, C_SUB, 1'b1);
    check_lit("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 1);
    apply(64'hDEAD, 64'hBEEF, C_R7, 1'b1);
    check_lit("rsvd7", 64'd0, 0, 0, 0, 1, 1);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, C_R1, 1'b1);
    check_lit("rsvd1", 64'd0, 0, 0, 0, 1, 1);
    apply(64'hF0F0, 64'h8000_0000_0000_FF00, C_AND, 1'b1);
    check_lit("and", 64'h0000_0000_0000_F000, 0, 0, 0, 0, 1);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, C_PASS, 1'b1);
    check_lit("pass_b", 64'h8000_0000_0000_0000, 0, 0, 1, 0, 1);
    apply(64'h00FF, 64'h0F0F, C_XOR, 1'b1);
`ifdef ALU64_XOR_EN
    check_lit("xor", 64'h0FF0, 0, 0, 0, 0, 1);
`else
    check_lit("xor_rsvd", 64'd0, 0, 0, 0, 1, 1);
`endif

    // Idle cycles hold the last result while out_valid drops.
    apply(64'd1, 64'd1, C_ADD, 1'b1);
    for (int i = 0; i < 3; i++) apply({$urandom, $urandom}, {$urandom, $urandom}, C_OR, 1'b0);
    check_lit("hold", 64'd2, 0, 0, 0, 0, 0);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 100; i++) begin
        apply({$urandom, $urandom}, {$urandom, $urandom}, rand_ops[k], ($urandom_range(0, 7) != 0));
      end
    end
    for (int i = 0; i < 100; i++) apply({$urandom, $urandom}, {$urandom, $urandom}, C_ADD, 1'b1);

    // Reset mid-stream with a valid op present must clear outputs without a clock edge.
    apply(64'h8000_0000_0000_0000, 64'd5, C_OR, 1'b1);
    A = 64'd7; B = 64'd9; cntrl = C_ADD; in_valid = 1'b1;
    #2;
    reset = 1'b1;
    exp_s = '0; exp_valid = 1'b0;
    #1;
    check_lit("async_reset", 64'd0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    apply(64'd3, 64'd4, C_ADD, 1'b1);
    check_lit("first_after_reset", 64'd7, 0, 0, 0, 0, 1);
    apply(64'd0, 64'd0, C_PASS, 1'b0);
    @(negedge clk);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu64.md
ALU64 -- requirements
Module: alu64

Interface
REQ-001 SHALL have parameter: WIDTH, 64, datapath width in bits; all arithmetic rules below are stated for WIDTH=64.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  operands and cntrl valid this cycle.
REQ-006 SHALL have port: A  input  64  operand A.
REQ-007 SHALL have port: B  input  64  operand B.
REQ-008 SHALL have port: cntrl  input  3  operation select.
REQ-009 SHALL have port: result  output  64  registered operation result.
REQ-010 SHALL have port: negative  output  1  registered result[63].
REQ-011 SHALL have port: zero  output  1  registered (result == 0).
REQ-012 SHALL have port: overflow  output  1  registered signed overflow.
REQ-013 SHALL have port: carry_out  output  1  registered carry out of bit 63.
REQ-014 SHALL have port: out_valid  output  1  outputs updated by an accepted operation.

Function
REQ-015 SHALL compute, by cntrl: 000 -> B; 010 -> A+B; 011 -> A-B; 100 -> A&B; 101 -> A|B; 110 -> A^B.
REQ-016 SHALL, for cntrl 001 and 111 (reserved), produce result 0, carry_out 0 and overflow 0.
REQ-017 SHALL implement subtract as A + ~B + 1: carry-in to bit 0 is 1 only for cntrl 011, else 0.
REQ-018 SHALL define the adder carry chain c[0..64], with carry_out = c[64] and overflow = c[63] XOR c[64].
REQ-019 SHALL use subtract carry_out semantics where 1 means no borrow, so A >= B unsigned gives 1.
REQ-020 SHALL force carry_out and overflow to 0 for all non-arithmetic cntrl codes.
REQ-021 SHALL compute negative = result[63] and zero = (result == 0) for every cntrl code, including pass and logic ops.
REQ-022 SHALL wrap addition and subtraction modulo 2^64 with no saturation.
REQ-023 SHALL register result and all four flags on the rising clk edge when in_valid=1, giving 1-cycle latency.
REQ-024 SHALL hold result and the flags unchanged on any edge where in_valid=0.
REQ-025 SHALL register out_valid <= in_valid every cycle.
REQ-026 SHALL accept back-to-back operations every cycle with no stall or backpressure.

Reset
REQ-027 SHALL, while reset=1 and independent of clk, force result=0, negative=0, zero=0, overflow=0, carry_out=0 and out_valid=0.
REQ-028 SHALL keep zero at 0 during reset; zero becomes meaningful only once out_valid=1.
REQ-029 SHALL discard any operation presented in the cycle reset deasserts if the edge coincides with reset=1.
REQ-030 SHALL accept the first operation on the first rising edge with reset=0.

Configuration
REQ-031 SHALL use macro ALU64_XOR_EN to control the XOR operation.
REQ-032 SHALL, when ALU64_XOR_EN is defined, support cntrl 110 as A^B.
REQ-033 SHALL, when ALU64_XOR_EN is undefined, treat cntrl 110 as reserved per REQ-016; all other operations are unaffected.

Verification
REQ-034 SHALL verify: ADD A=0x1, B=0x1 -> result 0x2, carry_out 0, overflow 0, negative 0, zero 0 one cycle after acceptance.
REQ-035 SHALL verify: ADD A=0xFFFFFFFFFFFFFFFF, B=0x1 -> result 0, carry_out 1, overflow 0, zero 1.
REQ-036 SHALL verify: ADD A=B=0x8000000000000000 -> result 0, carry_out 1, overflow 1, negative 0, zero 1.
REQ-037 SHALL verify: SUB A=B=0x111 -> result 0, carry_out 1, overflow 0, zero 1; and SUB A=0x8000000000000000, B=0x0FFFFFFFFFFFFFFF -> result 0x7000000000000001, carry_out 1, overflow 1, negative 0, zero 0.
REQ-038 SHALL verify: 100 random A/B per op for PASS_B/SUB/AND/OR/XOR -> result and negative/zero match the reference model; reserved cntrl 111 -> result 0, zero 1.
REQ-039 SHALL verify: reset asserted mid-stream with in_valid=1 -> all outputs 0 immediately (asynchronously); in_valid=0 for 3 cycles -> outputs held and out_valid 0.
